ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage directly upstream of the instruction decoder/controller. Holds the PC and issues one-outstanding-request fetches to instruction memory over a req/ack handshake. Buffers returned words in a 2-entry FIFO and presents the head instruction with its PC plus pre-extracted `op`/`funct3` fields to the controller. Jump/branch redirects from the execute stage flush the buffer and restart fetch.

## Interface
- `XLEN`, 32: address/data width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `clk` in 1: sole clock; all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request (registered).
- `imem_addr` out XLEN: fetch address, word aligned (registered).
- `imem_ack` in 1: request accepted and `imem_rdata` valid this cycle.
- `imem_rdata` in 32: fetched instruction word.
- `inst_valid` out 1: FIFO head is valid.
- `inst` out 32: FIFO head instruction.
- `inst_pc` out XLEN: PC of FIFO head.
- `op` out 7: `inst[6:0]` when `inst_valid`, else 0.
- `funct3` out 3: `inst[14:12]` when `inst_valid`, else 0.
- `inst_ready` in 1: downstream consumes head when `inst_valid && inst_ready` (pop).
- `redirect_valid` in 1: jump/taken-branch redirect.
- `redirect_pc` in XLEN: redirect target; bits [1:0] ignored (treated as 00).

## Operation
- State: `fetch_pc`, `pend_pc`, FIFO (2 entries of {inst, pc}, `count` 0..2), FSM {IDLE, FETCH, DISCARD}.
- Reset: state IDLE, `fetch_pc`=RESET_PC, `count`=0, `imem_req`=0, `imem_addr`=RESET_PC; hence `inst_valid`=0, `op`=0, `funct3`=0. Reset overrides ack, pop and redirect in the same cycle.
- IDLE: if no redirect and `count`<2: assert `imem_req`, `imem_addr`=`fetch_pc`, go FETCH. Ack in IDLE is ignored.
- FETCH: `imem_req` and `imem_addr` held stable until `imem_ack`. On ack without redirect:
  - push {`imem_rdata`, `imem_addr`};
  - `fetch_pc`+=4 (wraps modulo 2^XLEN).
  - Let `cnt_next`=`count`+1-pop. If `cnt_next`<2: stay FETCH with `imem_addr`=new `fetch_pc`, keeping `imem_req` high. Otherwise drop `imem_req` and go IDLE.
- Redirect, highest priority; flushes FIFO (`count`=0) in the same edge, and any same-cycle pop is irrelevant.
  - IDLE: `fetch_pc`=`redirect_pc`, stay IDLE.
  - FETCH with ack this cycle: discard data, `fetch_pc`=`redirect_pc`, go IDLE.
  - FETCH without ack: `pend_pc`=`redirect_pc`, go DISCARD; req/addr stay held.
  - DISCARD: later redirects overwrite `pend_pc` (latest wins). On ack: discard data, `fetch_pc`=`pend_pc`, go IDLE.
- FIFO: pop and push in the same cycle are both honored. With `count`=2, no push ever occurs, because no request is outstanding. Order is strictly preserved.

## Timing
- Fetch start: reset released at edge 0 → `imem_req`=1 in cycle 1.
- Latency: ack in cycle N → `inst_valid`=1 in cycle N+1.
- Throughput: with the memory acking every cycle and `inst_ready` held at 1, one instruction per cycle steady-state.
- Redirect at cycle N:
  - `inst_valid`=0 in cycle N+1.
  - New-target request visible no earlier than N+2, or 2 cycles after the outstanding ack when in DISCARD.
- Backpressure: with `inst_ready`=0, at most 2 instructions are buffered and `imem_req` falls once `cnt_next`=2.
- `op`/`funct3` are combinational from the FIFO head only. An empty FIFO presents zeros, which the controller decodes as a bubble.

## Test plan
- Reset, imem acks every request in the same cycle, `inst_ready`=1 → PCs 0,4,8,12 appear on consecutive cycles from cycle 2; `op`/`funct3` match `imem_rdata` (e.g. 0x00A00093 → op=0010011, funct3=000).
- Hold `inst_ready`=0 → exactly 2 entries (PC 0, 4) held, `imem_req` low. Release → PC 0 then PC 4, then fetching resumes at 8.
- Redirect to 0x100 while FETCH waits 3 cycles for ack → the stale word is dropped and never reaches `inst_valid`. Next request `imem_addr`=0x100.
- Two redirects (0x200, then 0x300) during DISCARD → fetch resumes at 0x300. Redirect 0x103 → `imem_addr`=0x100.
- Redirect simultaneous with ack and pop with `count`=1 → FIFO empty next cycle, `fetch_pc`=target, data dropped.
- Assert `rst` mid-FETCH with ack high → next cycle outputs at reset values, `imem_addr`=RESET_PC, no push.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction-memory and decoder-side handshake bundle for the fetch stage
interface ifetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic [6:0]      op;
  logic [2:0]      funct3;
  logic            inst_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, op, funct3,
    input  imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, op, funct3,
    output imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC holder issuing single-outstanding fetches into a 2-entry buffer, flushed on redirect
module ifetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  ifetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n, pend_pc, pend_pc_n, addr, addr_n, rpc, pc_inc;
  logic req, req_n, push, pop, rd, valid;
  logic [1:0] count, cnt_next;
  logic [31:0] buf_inst [2];
  logic [XLEN-1:0] buf_pc [2];
  assign rpc = bus.redirect_pc & ~XLEN'(3);
  assign pc_inc = fetch_pc + XLEN'(4);
  assign valid = count != 2'd0;
  assign pop = valid & bus.inst_ready;
  assign cnt_next = count + 2'd1 - {1'b0, pop};
  always_comb begin
    state_n = state;
    fetch_pc_n = fetch_pc;
    pend_pc_n = pend_pc;
    addr_n = addr;
    req_n = req;
    push = 1'b0;
    unique case (state)
      IDLE:
        if (bus.redirect_valid) fetch_pc_n = rpc;
        else if (count != 2'd2) begin
          req_n = 1'b1;
          addr_n = fetch_pc;
          state_n = FETCH;
        end
      FETCH:
        if (bus.redirect_valid) begin
          if (bus.imem_ack) begin
            fetch_pc_n = rpc;
            req_n = 1'b0;
            state_n = IDLE;
          end else begin
            pend_pc_n = rpc;
            state_n = DISCARD;
          end
        end else if (bus.imem_ack) begin
          push = 1'b1;
          fetch_pc_n = pc_inc;
          if (cnt_next < 2'd2) addr_n = pc_inc;
          else begin
            req_n = 1'b0;
            state_n = IDLE;
          end
        end
      DISCARD: begin
        pend_pc_n = bus.redirect_valid ? rpc : pend_pc;
        if (bus.imem_ack) begin
          fetch_pc_n = bus.redirect_valid ? rpc : pend_pc;
          req_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      pend_pc <= '0;
      addr <= RESET_PC;
      req <= 1'b0;
      count <= 2'd0;
      rd <= 1'b0;
    end else begin
      state <= state_n;
      fetch_pc <= fetch_pc_n;
      pend_pc <= pend_pc_n;
      addr <= addr_n;
      req <= req_n;
      count <= bus.redirect_valid ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
      rd <= bus.redirect_valid ? 1'b0 : rd ^ pop;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      buf_inst[rd ^ count[0]] <= bus.imem_rdata;
      buf_pc[rd ^ count[0]] <= addr;
    end
  end
  assign bus.imem_req = req;
  assign bus.imem_addr = addr;
  assign bus.inst_valid = valid;
  assign bus.inst = buf_inst[rd];
  assign bus.inst_pc = buf_pc[rd];
  assign bus.op = valid ? buf_inst[rd][6:0] : 7'd0;
  assign bus.funct3 = valid ? buf_inst[rd][14:12] : 3'd0;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed cycle table plus randomized run against a PC-stream reference model
module tb_ifetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  ifetch_unit_if #(.XLEN(32)) bus ();
  ifetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  typedef struct {
    logic rst, ack;
    logic [31:0] rdata;
    logic ready, rv;
    logic [31:0] rpc;
    logic e_req;
    logic [31:0] e_addr;
    logic e_valid;
    logic [31:0] e_inst, e_pc;
    logic [6:0] e_op;
    logic [2:0] e_f3;
  } vec_t;
  localparam logic [31:0] D0 = 32'h00A00093, D1 = 32'h0020C113, D2 = 32'h00002003;
  localparam logic [31:0] D3 = 32'h00000063, D4 = 32'h00108093, BAD = 32'hDEADBEEF;
  vec_t tbl [18];
  function automatic vec_t v(input logic r, input logic a, input logic [31:0] d, input logic rdy,
                             input logic rv, input logic [31:0] rpc, input logic er,
                             input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                             input logic [31:0] ep, input logic [6:0] eo, input logic [2:0] ef);
    vec_t t;
    t.rst = r; t.ack = a; t.rdata = d; t.ready = rdy; t.rv = rv; t.rpc = rpc;
    t.e_req = er; t.e_addr = ea; t.e_valid = ev; t.e_inst = ei; t.e_pc = ep; t.e_op = eo; t.e_f3 = ef;
    return t;
  endfunction
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic a, input logic [31:0] d, input logic rdy,
                       input logic rv, input logic [31:0] rpc);
    rst = r;
    bus.imem_ack = a;
    bus.imem_rdata = d;
    bus.inst_ready = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
  endtask
  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
  endtask
  initial begin
    logic [31:0] exp_pc, prev_addr, rpc, d;
    logic prev_req, prev_ack, prev_rv, rdy, rv, ack;
    int pops;
    tbl[0]  = v(0, 0, 0,   1, 0, 0,          0, 32'h0,   0, 0,  0,       7'h00, 3'd0);
    tbl[1]  = v(0, 1, D0,  1, 0, 0,          1, 32'h0,   0, 0,  0,       7'h00, 3'd0);
    tbl[2]  = v(0, 1, D1,  1, 0, 0,          1, 32'h4,   1, D0, 32'h0,   7'h13, 3'd0);
    tbl[3]  = v(0, 1, D2,  1, 0, 0,          1, 32'h8,   1, D1, 32'h4,   7'h13, 3'd4);
    tbl[4]  = v(0, 1, D3,  0, 0, 0,          1, 32'hC,   1, D2, 32'h8,   7'h03, 3'd2);
    tbl[5]  = v(0, 1, BAD, 0, 0, 0,          0, 32'hC,   1, D2, 32'h8,   7'h03, 3'd2);
    tbl[6]  = v(0, 0, 0,   1, 0, 0,          0, 32'hC,   1, D2, 32'h8,   7'h03, 3'd2);
    tbl[7]  = v(0, 0, 0,   0, 0, 0,          0, 32'hC,   1, D3, 32'hC,   7'h63, 3'd0);
    tbl[8]  = v(0, 0, 0,   0, 1, 32'h200,    1, 32'h10,  1, D3, 32'hC,   7'h63, 3'd0);
    tbl[9]  = v(0, 0, 0,   0, 1, 32'h303,    1, 32'h10,  0, 0,  0,       7'h00, 3'd0);
    tbl[10] = v(0, 1, BAD, 1, 0, 0,          1, 32'h10,  0, 0,  0,       7'h00, 3'd0);
    tbl[11] = v(0, 0, 0,   1, 0, 0,          0, 32'h10,  0, 0,  0,       7'h00, 3'd0);
    tbl[12] = v(0, 1, D4,  1, 0, 0,          1, 32'h300, 0, 0,  0,       7'h00, 3'd0);
    tbl[13] = v(0, 1, BAD, 1, 1, 32'h400,    1, 32'h304, 1, D4, 32'h300, 7'h13, 3'd0);
    tbl[14] = v(0, 0, 0,   1, 0, 0,          0, 32'h304, 0, 0,  0,       7'h00, 3'd0);
    tbl[15] = v(1, 1, BAD, 1, 0, 0,          1, 32'h400, 0, 0,  0,       7'h00, 3'd0);
    tbl[16] = v(0, 0, 0,   1, 0, 0,          0, 32'h0,   0, 0,  0,       7'h00, 3'd0);
    tbl[17] = v(0, 0, 0,   1, 0, 0,          1, 32'h0,   0, 0,  0,       7'h00, 3'd0);
    do_reset();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk($sformatf("row%0d imem_req", i), 32'(bus.imem_req), 32'(tbl[i].e_req));
      chk($sformatf("row%0d imem_addr", i), bus.imem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d inst_valid", i), 32'(bus.inst_valid), 32'(tbl[i].e_valid));
      chk($sformatf("row%0d op", i), 32'(bus.op), 32'(tbl[i].e_op));
      chk($sformatf("row%0d funct3", i), 32'(bus.funct3), 32'(tbl[i].e_f3));
      if (tbl[i].e_valid) begin
        chk($sformatf("row%0d inst", i), bus.inst, tbl[i].e_inst);
        chk($sformatf("row%0d inst_pc", i), bus.inst_pc, tbl[i].e_pc);
      end
      drive(tbl[i].rst, tbl[i].ack, tbl[i].rdata, tbl[i].ready, tbl[i].rv, tbl[i].rpc);
    end
    do_reset();
    @(negedge clk);
    exp_pc = 32'h0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_rv = 1'b0; prev_addr = 32'h0;
    pops = 0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (prev_rv) chk("valid after redirect", 32'(bus.inst_valid), 32'd0);
      if (prev_req && !prev_ack) begin
        chk("req held until ack", 32'(bus.imem_req), 32'd1);
        chk("addr held until ack", bus.imem_addr, prev_addr);
      end
      if (bus.imem_req) chk("addr word aligned", 32'(bus.imem_addr[1:0]), 32'd0);
      if (!bus.inst_valid) chk("bubble fields zero", {22'd0, bus.op, bus.funct3}, 32'd0);
      rdy = $urandom_range(0, 9) < 7;
      rv = $urandom_range(0, 13) == 0;
      rpc = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : ($urandom & 32'h0000_0FFF);
      if (rv) exp_pc = rpc & ~32'h3;
      else if (bus.inst_valid && rdy) begin
        d = memfn(exp_pc);
        chk("stream pc", bus.inst_pc, exp_pc);
        chk("stream inst", bus.inst, d);
        chk("stream op/funct3", {22'd0, bus.op, bus.funct3}, {22'd0, d[6:0], d[14:12]});
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      ack = bus.imem_req ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 4) == 0);
      d = (ack && bus.imem_req) ? memfn(bus.imem_addr) : $urandom;
      prev_req = bus.imem_req;
      prev_addr = bus.imem_addr;
      prev_ack = ack;
      prev_rv = rv;
      drive(1'b0, ack, d, rdy, rv, rpc);
    end
    chk("random run progress", 32'(pops >= 400), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
